posit_add_arbiter: RTL
======================

# posit_add_arbiter

Round-robin scheduler that shares one pipelined 32-bit posit adder (`positadd_8`-class unit: in1/in2/start in, result/inf/zero/done out, fixed latency, no stall) between NREQ independent requesters. The block accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the adder. It tracks each in-flight operation's requester ID in a tag shift register aligned with the adder latency. It returns each result, with its inf/zero flags, to the originating requester through a holding register.

## Interface
- NREQ, 4, number of requesters (2..8)
- LATENCY, 8, adder cycles from start sampled high to done high (≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has an operand pair
- req_ready  out  NREQ  one-hot grant; handshake when valid&ready
- req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
- req_b  in  NREQ*32  operand B, same packing
- rsp_valid  out  NREQ  result held for requester i
- rsp_ready  in  NREQ  requester i consumes result
- rsp_result  out  NREQ*32  held result per requester
- rsp_inf, rsp_zero  out  NREQ each  held flags per requester
- add_in1, add_in2  out  32 each  registered adder operands
- add_start  out  1  registered issue strobe
- add_result  in  32  adder result
- add_inf, add_zero, add_done  in  1 each  adder flags / done
- inflight  out  8  operations issued, not yet returned by adder
- err  out  1  sticky: expected done missing

## Operation
- busy[i] set on requester i's request handshake. Cleared on its rsp handshake (rsp_valid[i]&rsp_ready[i]). A busy requester is ineligible, so each requester has at most one outstanding op. This guarantees a free holding register for every returning result; the adder never needs back-pressure.
- Eligible[i] = req_valid[i] & ~busy[i]. Grant is combinational: first eligible index at or after pointer ptr, wrapping modulo NREQ. req_ready is that one-hot, or zero when none are eligible.
- On a handshake by requester g: register add_in1=req_a[g], add_in2=req_b[g], add_start=1, and push {1, g} into tag stage 0. ptr <= (g+1) mod NREQ. With no handshake: add_start=0, push {0, x}, operands hold, ptr holds.
- The tag shift register is LATENCY entries deep. Its tail entry is aligned with add_done.
- When tail valid and add_done=1: capture add_result/add_inf/add_zero into holding register of tail ID, set its rsp_valid.
- When tail valid and add_done=0: set err (sticky). Drop the op and clear busy of tail ID.
- When add_done=1 and tail invalid (stale done, e.g. after reset): ignore.
- inflight = count of valid tag entries. +1 on push, −1 on tail valid, both → unchanged.
- Reset: ptr=0, busy=0, tags invalid, inflight=0, err=0, add_start=0, add_in1/add_in2=0, rsp_valid=0, rsp_result/rsp_inf/rsp_zero=0, req_ready=0. Ops in flight at reset are discarded.

## Timing
- Handshake in cycle t → add_start high in cycle t+1 → add_done expected in cycle t+1+LATENCY → rsp_valid high from cycle t+2+LATENCY.
- rsp_valid, result and flags are stable until the rsp handshake; rsp_valid falls the cycle after.
- busy clears the cycle after the rsp handshake. The same requester may be granted in that cycle at earliest, giving a minimum per-requester issue interval of LATENCY+3 cycles with rsp_ready tied high.
- Peak throughput: one issue per cycle across requesters. Simultaneous return to requester j and issue by requester k≠j in one cycle is legal.
- An rsp handshake and a new result for the same requester cannot coincide, because busy prevents it.
- err rises the cycle after the missing done and stays high until rst_n is asserted.

## Test plan
- Single op: req 0 a=0x40000000, b=0x40000000, stub adder adds with LATENCY=8 → req_ready[0]=1 at t, add_start at t+1, rsp_valid[0] at t+10 with stub result, inflight 1 for cycles t+2..t+9.
- All four requesters are valid every cycle with rsp_ready=1. Grants run 0,1,2,3 in consecutive cycles, and then none are granted until the busy flags clear. Each result routes to the correct index with no cross-talk.
- Round-robin fairness: ptr=2, requesters 0 and 3 valid → grant 3, then 0.
- Back-pressure: rsp_ready[1]=0 for 20 cycles → rsp_valid[1] and data hold. Requester 1 is never regranted while others continue issuing. After rsp_ready[1]=1, requester 1 is regranted the following cycle.
- Missing done: stub suppresses add_done for one op → err=1 from the next cycle. That requester returns to eligible. A later stray add_done with an invalid tail is ignored.
- Reset mid-flight: rst_n low with 3 ops in flight → all outputs at reset values immediately. Late add_done pulses after release produce no rsp_valid and no err.

Source files
------------

// File: rtl/posit_add_arbiter_if.sv
// Bundle of requester handshakes and adder-side signals for posit_add_arbiter.
// slave: the arbiter's view. master: the requesters plus the adder (the environment).
interface posit_add_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [NREQ*32-1:0]   rsp_result;
  logic [NREQ-1:0]      rsp_inf;
  logic [NREQ-1:0]      rsp_zero;
  logic [31:0]          add_in1;
  logic [31:0]          add_in2;
  logic                 add_start;
  logic [31:0]          add_result;
  logic                 add_inf;
  logic                 add_zero;
  logic                 add_done;
  logic [7:0]           inflight;
  logic                 err;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
           add_result, add_inf, add_zero, add_done,
    output req_ready, rsp_valid, rsp_result, rsp_inf, rsp_zero,
           add_in1, add_in2, add_start, inflight, err
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
           add_result, add_inf, add_zero, add_done,
    input  req_ready, rsp_valid, rsp_result, rsp_inf, rsp_zero,
           add_in1, add_in2, add_start, inflight, err
  );
endinterface

// File: rtl/posit_add_arbiter.sv
// Round-robin sharing of one fixed-latency posit adder among NREQ requesters.
// Each requester has at most one op outstanding; results come back through a
// per-requester holding register, routed by a tag pipeline aligned with add_done.
module posit_add_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  posit_add_arbiter_if.slave bus
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IDW-1:0] id_t;

  // Issue-side state
  logic [NREQ-1:0]      busy_q, busy_d;
  id_t                  ptr_q;
  logic                 add_start_q;
  logic [31:0]          add_in1_q, add_in2_q;
  id_t                  iss_id_q;

  // Tag pipeline and status
  logic [LATENCY-1:0]   tag_vld_q;
  id_t [LATENCY-1:0]    tag_id_q;
  logic [7:0]           inflight_q, inflight_d;
  logic                 err_q;

  // Holding registers
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0]      rsp_inf_q, rsp_zero_q;
  logic [NREQ*32-1:0]   rsp_result_q;

  // Combinational helpers
  logic [NREQ-1:0]      eligible, gnt_oh, tail_oh, rsp_hs;
  logic                 gnt_any;
  id_t                  gnt_id, cand;
  logic [31:0]          sel_a, sel_b;
  logic                 tail_vld, ret, miss;
  id_t                  tail_id;

  // Round-robin grant: first eligible index at or after ptr, wrapping.
  always_comb begin
    eligible = bus.req_valid & ~busy_q & {NREQ{rst_n}};
    gnt_any  = 1'b0;
    gnt_id   = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = id_t'((32'(ptr_q) + k) % NREQ);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    gnt_oh = '0;
    if (gnt_any) gnt_oh[gnt_id] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_id == id_t'(i)) begin
        sel_a = bus.req_a[32*i +: 32];
        sel_b = bus.req_b[32*i +: 32];
      end
    end
  end

  // Return-side decode and next-state for busy, rsp_valid, inflight.
  always_comb begin
    tail_vld = tag_vld_q[LATENCY-1];
    tail_id  = tag_id_q[LATENCY-1];
    ret      = tail_vld & bus.add_done;
    miss     = tail_vld & ~bus.add_done;
    tail_oh  = '0;
    tail_oh[tail_id] = 1'b1;
    rsp_hs      = rsp_valid_q & bus.rsp_ready;
    busy_d      = (busy_q | gnt_oh) & ~rsp_hs & ~(miss ? tail_oh : '0);
    rsp_valid_d = (rsp_valid_q & ~rsp_hs) | (ret ? tail_oh : '0);
    inflight_d  = inflight_q;
    case ({add_start_q, tail_vld})
      2'b10:   inflight_d = inflight_q + 8'd1;
      2'b01:   inflight_d = inflight_q - 8'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Issue register: operands, start strobe, requester id, pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_start_q <= 1'b0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
      iss_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      add_start_q <= gnt_any;
      if (gnt_any) begin
        add_in1_q <= sel_a;
        add_in2_q <= sel_b;
        iss_id_q  <= gnt_id;
        ptr_q     <= (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + id_t'(1);
      end
    end
  end

  // Tag pipeline. The issue register {add_start_q, iss_id_q} acts as the push
  // stage, so the LATENCY-deep tail lines up with the adder's done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= {tag_vld_q[LATENCY-2:0], add_start_q};
      tag_id_q  <= {tag_id_q[LATENCY-2:0], iss_id_q};
    end
  end

  // Busy flags, in-flight count and sticky missing-done error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      err_q      <= err_q | miss;
    end
  end

  // Holding registers capture the adder output for the tail's requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_inf_q    <= '0;
      rsp_zero_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (ret && tail_oh[i]) begin
          rsp_result_q[32*i +: 32] <= bus.add_result;
          rsp_inf_q[i]             <= bus.add_inf;
          rsp_zero_q[i]            <= bus.add_zero;
        end
      end
    end
  end

  assign bus.req_ready  = gnt_oh;
  assign bus.add_start  = add_start_q;
  assign bus.add_in1    = add_in1_q;
  assign bus.add_in2    = add_in2_q;
  assign bus.inflight   = inflight_q;
  assign bus.err        = err_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_inf    = rsp_inf_q;
  assign bus.rsp_zero   = rsp_zero_q;
endmodule
